// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register between two pipeline stages.
// Control bits are masked to zero whenever no entry is presented (bubble),
// while the payload keeps its last value so idle cycles do not toggle the bus.
// Build option: define PIPE_SKID_EN to add a one-entry skid register
// (capacity 2, in_ready straight from a flop); without it the stage holds a
// single entry and in_ready is combinational from out_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Main register: the entry currently presented downstream.
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;

  logic accept;
  logic consume;

  assign consume   = main_valid_q & out_ready;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

`ifdef PIPE_SKID_EN
  // Skid register catches the entry accepted while main is stalled.
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q;

  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q & ~flush;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Next-state: flush clears both slots; skid refills main on consume;
  // a new entry lands in main if it will be free, otherwise in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so no accept can coincide here
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end else begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end
    end
  end

  // State registers; in_ready is registered as the inverse of next skid-valid.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end
`else
  // Single slot: ready when empty or when the held entry leaves this cycle.
  assign in_ready  = ~main_valid_q | out_ready;
  assign accept    = in_valid & in_ready & ~flush;
  assign occupancy = {1'b0, main_valid_q};

  // Next-state: flush empties the slot; otherwise load on accept, drain on consume.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
    end else if (consume) begin
      main_valid_d = 1'b0;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
    end
  end
`endif

endmodule
